// File: rtl/ula_pkg.sv
// Shared ULA definitions: result width/type and instruction encodings used by
// the ULA, its result FIFO and the bench.
package ula_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] ula_result_t;

  // Instruction encoding shared with the ULA datapath.
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_SHL = 4'h5;
  localparam logic [OP_W-1:0] OP_SHR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOP = 4'hF;

  // Saturating increment for the drop counter; holds at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ula_fifo_mem.sv
// DEPTH x DATA_W result storage: registered write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the controller.
module ula_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the accepted result into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ula_result_fifo.sv
// In-order result buffer behind the ULA. Show-ahead head on a valid/ready
// port, occupancy flags, sticky overflow and a saturating drop counter.
module ula_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ula_pkg::DATA_W,
  parameter int DROP_W = 16,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic              clk_ula,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  import ula_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ula_result_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic              push, pop, accept, drop;

  // Flags come from registered count only, so they can never both be set.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign push   = valid_out;
  assign pop    = !empty && res_ready;
  // A full FIFO still accepts when the head leaves in the same edge.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  ula_fifo_mem #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk_ula),
    .we   (accept && rst),
    .waddr(wr_ptr),
    .wdata(data_out),
    .raddr(rd_ptr),
    .rdata(head)
  );

  // Outputs depend only on registered state; no path from data_out/valid_out.
  assign res_valid = !empty;
  assign res_data  = empty ? '0 : head;

  // Pointer and occupancy control; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_ula) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  // Overflow bookkeeping; a drop in the clearing cycle takes priority.
  always_ff @(posedge clk_ula) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)          drop_cnt <= DROP_W'(1);
      else if (!(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
